// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and line idle level.
// Used by uart_tx_engine now and by the future uart_rx.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_tx_engine_if.sv
// Bridge-facing signal bundle of the UART transmitter.
interface uart_tx_engine_if #(
  parameter int N = 8
);

  // Handshake: the master raises tx_external with to_uart valid; the byte is
  // taken on any rising edge where uart_busy is low (uart_busy acts as !ready).
  // Strobes seen while uart_busy is high are dropped. end_tx pulses for one
  // cycle when the stop bit finishes.
  logic         tx_external;
  logic [N-1:0] to_uart;
  logic         tx_serial;
  logic         uart_busy;
  logic         end_tx;

  modport master (
    output tx_external,
    output to_uart,
    input  tx_serial,
    input  uart_busy,
    input  end_tx
  );

  modport slave (
    input  tx_external,
    input  to_uart,
    output tx_serial,
    output uart_busy,
    output end_tx
  );

endinterface : uart_tx_engine_if

// File: rtl/uart_tx_engine_baud_tick_gen.sv
// Bit-period counter: one-cycle tick at count CLKS_PER_BIT-1, cleared on
// frame accept so bit boundaries line up with the accepting edge.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_baud_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_baud_cnt <= '0;
    end else if (r_baud_cnt == LAST) begin
      r_baud_cnt <= '0;
    end else begin
      r_baud_cnt <= r_baud_cnt + 1'b1;
    end
  end

  assign tick = (r_baud_cnt == LAST);

endmodule : baud_tick_gen

// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, N data bits LSB first, optional even parity,
// one stop bit. Define UART_TX_PARITY_EN to insert the parity bit.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int N            = 8
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_engine_if.slave   bus,
  output uart_state_e       o_dbg_state
);

  localparam int BIT_W = $clog2(N) + 1;

  uart_state_e      r_state;
  logic [N-1:0]     r_shift_reg;
  logic [BIT_W-1:0] r_bit_idx;
  logic             r_tx_serial;
  logic             r_uart_busy;
  logic             r_end_tx;
`ifdef UART_TX_PARITY_EN
  logic             r_parity_acc;
  logic             w_parity_next;
`endif

  logic         w_accept;
  logic         w_tick;
  logic         w_last_bit;
  logic [N-1:0] w_shift_next;

  assign w_accept     = (r_state == ST_IDLE) && bus.tx_external;
  assign w_last_bit   = (r_bit_idx == BIT_W'(N - 1));
  assign w_shift_next = r_shift_reg >> 1;
`ifdef UART_TX_PARITY_EN
  assign w_parity_next = r_parity_acc ^ r_shift_reg[0];
`endif

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(w_accept),
    .tick (w_tick)
  );

  // The line level for the next bit is loaded on the boundary edge so
  // tx_serial stays a plain register with no decode behind it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_shift_reg  <= '0;
      r_bit_idx    <= '0;
      r_tx_serial  <= IDLE_LEVEL;
      r_uart_busy  <= 1'b0;
      r_end_tx     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity_acc <= 1'b0;
`endif
    end else begin
      r_end_tx <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.tx_external) begin
            r_shift_reg  <= bus.to_uart;
            r_bit_idx    <= '0;
            r_tx_serial  <= 1'b0;
            r_uart_busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity_acc <= 1'b0;
`endif
            r_state      <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_tx_serial <= r_shift_reg[0];
            r_state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shift_reg <= w_shift_next;
            r_bit_idx   <= r_bit_idx + 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity_acc <= w_parity_next;
`endif
            if (w_last_bit) begin
`ifdef UART_TX_PARITY_EN
              r_tx_serial <= w_parity_next;
              r_state     <= ST_PARITY;
`else
              r_tx_serial <= IDLE_LEVEL;
              r_state     <= ST_STOP;
`endif
            end else begin
              r_tx_serial <= w_shift_next[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            r_tx_serial <= IDLE_LEVEL;
            r_state     <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (w_tick) begin
            r_tx_serial <= IDLE_LEVEL;
            r_uart_busy <= 1'b0;
            r_end_tx    <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_tx_serial <= IDLE_LEVEL;
          r_uart_busy <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_serial = r_tx_serial;
  assign bus.uart_busy = r_uart_busy;
  assign bus.end_tx    = r_end_tx;
  assign o_dbg_state   = r_state;

endmodule : uart_tx_engine

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine (CLKS_PER_BIT = 4, N = 8); follows
// UART_TX_PARITY_EN when defined.
module tb_uart_tx_engine;
  import uart_pkg::*;

  localparam int C = 4;
  localparam int N = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = N + 3;
`else
  localparam int NBITS = N + 2;
`endif
  localparam int F = NBITS * C;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  uart_state_e dbg_state;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_engine_if #(.N(N)) bus ();

  uart_tx_engine #(
    .CLKS_PER_BIT(C),
    .N(N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [N-1:0] exp_q[$];
  int unsigned  start_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           end_cnt = 0;
  int           frames_seen = 0;
  bit           mon_busy = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) if (bus.end_tx === 1'b1) end_cnt++;

  // ---------------- monitor ----------------
  task automatic frame_check();
    logic [N-1:0]     b;
    logic [NBITS-1:0] fb;
    int               bad;
    bit               have;
    mon_busy = 1'b1;
    start_q.push_back(cyc);
    frames_seen++;
    have = (exp_q.size() != 0);
    chk(have, "frame_expected", 32'(frames_seen), 32'(frames_seen - 1));
    b = have ? exp_q.pop_front() : '0;
`ifdef UART_TX_PARITY_EN
    fb = {1'b1, ^b, b, 1'b0};
`else
    fb = {1'b1, b, 1'b0};
`endif
    for (int bi = 0; bi < NBITS; bi++) begin
      bad = 0;
      for (int c = 0; c < C; c++) begin
        if (bi != 0 || c != 0) @(negedge clk);
        if (reset) begin
          mon_busy = 1'b0;
          return;
        end
        if (bus.tx_serial !== fb[bi] || bus.uart_busy !== 1'b1 || bus.end_tx !== 1'b0) bad++;
      end
      if (have) chk(bad == 0, $sformatf("frame_bit%0d_byte%02h", bi, b), 32'(bad), 32'd0);
    end
    @(negedge clk);
    if (!reset)
      chk(bus.end_tx === 1'b1 && bus.uart_busy === 1'b0 && bus.tx_serial === 1'b1,
          $sformatf("frame_end_byte%02h", b),
          {29'd0, bus.end_tx, bus.uart_busy, bus.tx_serial}, 32'b101);
    mon_busy = 1'b0;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset && bus.tx_serial === 1'b0) frame_check();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [N-1:0] b, output int unsigned acc);
    @(posedge clk); #1;
    bus.tx_external = 1'b1;
    bus.to_uart     = b;
    exp_q.push_back(b);
    @(posedge clk); #1;
    acc = cyc;
    bus.tx_external = 1'b0;
    bus.to_uart     = N'($urandom_range(0, 255));
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 10 * F && !done; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && bus.uart_busy === 1'b0 && !mon_busy) done = 1'b1;
    end
    if (!done) chk(1'b0, "wait_idle_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic bridge_write(input logic [N-1:0] b);
    int unsigned acc;
    bit          free = 1'b0;
    for (int i = 0; i < 10 * F && !free; i++) begin
      @(posedge clk); #1;
      if (bus.uart_busy === 1'b0) free = 1'b1;
    end
    if (!free) chk(1'b0, "bridge_busy_timeout", 32'd1, 32'd0);
    send_byte(b, acc);
  endtask

  // ---------------- directed stimulus ----------------
  logic [N-1:0] pat [5] = '{8'hA5, 8'h07, 8'h00, 8'hFF, 8'h80};

  initial begin : stim
    int unsigned acc;
    int          f0, e0, s0;

    bus.tx_external = 1'b0;
    bus.to_uart     = '0;
    reset           = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(bus.tx_serial === 1'b1, "reset_tx_serial", 32'(bus.tx_serial), 32'd1);
    chk(bus.uart_busy === 1'b0, "reset_uart_busy", 32'(bus.uart_busy), 32'd0);
    chk(bus.end_tx === 1'b0, "reset_end_tx", 32'(bus.end_tx), 32'd0);
    chk(dbg_state == ST_IDLE, "reset_state", 32'(dbg_state), 32'(ST_IDLE));

    // Reset and strobe together: reset wins.
    @(posedge clk); #1;
    bus.tx_external = 1'b1;
    bus.to_uart     = 8'hA5;
    @(posedge clk); #1;
    reset           = 1'b0;
    bus.tx_external = 1'b0;
    @(negedge clk);
    chk(bus.uart_busy === 1'b0, "reset_wins_busy", 32'(bus.uart_busy), 32'd0);
    chk(bus.tx_serial === 1'b1, "reset_wins_tx", 32'(bus.tx_serial), 32'd1);
    repeat (2 * C) @(posedge clk); #1;
    chk(frames_seen == 0, "reset_wins_no_frame", 32'(frames_seen), 32'd0);

    // Single frames with start aligned to the accepting edge.
    foreach (pat[i]) begin
      f0 = frames_seen;
      e0 = end_cnt;
      send_byte(pat[i], acc);
      wait_idle();
      chk(frames_seen == f0 + 1, "single_frame_count", 32'(frames_seen), 32'(f0 + 1));
      if (start_q.size() != 0)
        chk(start_q[$] == acc, "start_at_accept", start_q[$], acc);
      chk(end_cnt == e0 + 1, "single_end_tx_once", 32'(end_cnt), 32'(e0 + 1));
    end

    // Strobe 0xFF while busy at E+10 is dropped.
    f0 = frames_seen;
    send_byte(8'hA5, acc);
    repeat (9) @(posedge clk); #1;
    bus.tx_external = 1'b1;
    bus.to_uart     = 8'hFF;
    @(posedge clk); #1;
    bus.tx_external = 1'b0;
    wait_idle();
    repeat (2 * F) @(posedge clk); #1;
    chk(frames_seen == f0 + 1, "busy_strobe_ignored", 32'(frames_seen), 32'(f0 + 1));

    // Back-to-back with tx_external held high.
    f0 = frames_seen;
    s0 = start_q.size();
    @(posedge clk); #1;
    bus.tx_external = 1'b1;
    bus.to_uart     = 8'h3C;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    @(posedge clk); #1;
    bus.to_uart = 8'hC3;
    repeat (F + 1) @(posedge clk); #1;
    bus.tx_external = 1'b0;
    wait_idle();
    chk(frames_seen == f0 + 2, "b2b_frame_count", 32'(frames_seen), 32'(f0 + 2));
    if (start_q.size() >= s0 + 2)
      chk(start_q[s0 + 1] - start_q[s0] == F + 1, "b2b_start_gap",
          start_q[s0 + 1] - start_q[s0], 32'(F + 1));

    // Reset at E+17 aborts the frame without a completion pulse.
    e0 = end_cnt;
    send_byte(8'hA5, acc);
    repeat (16) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk(bus.tx_serial === 1'b1, "abort_tx_serial", 32'(bus.tx_serial), 32'd1);
    chk(bus.uart_busy === 1'b0, "abort_uart_busy", 32'(bus.uart_busy), 32'd0);
    chk(bus.end_tx === 1'b0, "abort_end_tx", 32'(bus.end_tx), 32'd0);
    chk(dbg_state == ST_IDLE, "abort_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (3 * F) @(posedge clk); #1;
    chk(end_cnt == e0, "abort_no_end_tx", 32'(end_cnt), 32'(e0));
    send_byte(8'h55, acc);
    wait_idle();
    chk(end_cnt == e0 + 1, "after_abort_end_tx", 32'(end_cnt), 32'(e0 + 1));

    // Bridge-style write: wait for !busy, then strobe.
    e0 = end_cnt;
    bridge_write(8'h5A);
    wait_idle();
    repeat (2 * F) @(posedge clk); #1;
    chk(end_cnt == e0 + 1, "bridge_end_tx_once", 32'(end_cnt), 32'(e0 + 1));

    chk(exp_q.size() == 0, "exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_uart_tx_engine
